// File: rtl/uart_auth_rcv_if.sv
// rtl/uart_auth_rcv_if.sv - serial line, rider sense and receive/authorization outputs
interface uart_auth_rcv_if;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       byte_vld;
  logic       frm_err;
  logic       pwr_up;

  modport master (
    output RX, rider_off,
    input  rx_data, byte_vld, frm_err, pwr_up
  );

  modport slave (
    input  RX, rider_off,
    output rx_data, byte_vld, frm_err, pwr_up
  );
endinterface

// File: rtl/uart_auth_rcv.sv
// rtl/uart_auth_rcv.sv - 8N1 UART receiver with rider-authorization power gating FSM
module uart_auth_rcv #(
  parameter int         BAUD_DIV  = 2604,
  parameter logic [7:0] GO_CODE   = 8'h47,
  parameter logic [7:0] STOP_CODE = 8'h53
) (
  input logic           clk,
  input logic           rst,
  uart_auth_rcv_if.slave bus
);
  localparam int CW = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] FULL     = CW'(BAUD_DIV);
  localparam logic [CW-1:0] FULL_M1  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} rcv_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_t;

  rcv_t          rcv, rcv_nxt;
  auth_t         auth, auth_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    data_r, data_nxt;
  logic          vld_r, vld_nxt;
  logic          err_r, err_nxt;
  logic          pwr_r;
  logic          expire;

  assign expire = (cnt == ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rcv     <= ARM;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_r  <= '0;
      vld_r   <= 1'b0;
      err_r   <= 1'b0;
      auth    <= OFF;
      pwr_r   <= 1'b0;
    end else begin
      rx_meta <= bus.RX;
      rx_s    <= rx_meta;
      rcv     <= rcv_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      data_r  <= data_nxt;
      vld_r   <= vld_nxt;
      err_r   <= err_nxt;
      auth    <= auth_nxt;
      pwr_r   <= (auth_nxt != OFF);
    end
  end

  // Counter is reused: up-count of idle cycles in ARM, down-count to mid-bit elsewhere.
  always_comb begin
    rcv_nxt   = rcv;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data_r;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (rcv)
      ARM: begin
        if (!rx_s) begin
          cnt_nxt = '0;
        end else if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          rcv_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      IDLE: begin
        if (!rx_s) begin
          cnt_nxt = HALF;
          rcv_nxt = START;
        end
      end
      START: begin
        if (!expire) begin
          cnt_nxt = cnt - ONE;
        end else if (rx_s) begin
          rcv_nxt = IDLE;
        end else begin
          bit_nxt = '0;
          cnt_nxt = FULL;
          rcv_nxt = DATA;
        end
      end
      DATA: begin
        if (!expire) begin
          cnt_nxt = cnt - ONE;
        end else begin
          shift_nxt = {rx_s, shift[7:1]};
          cnt_nxt   = FULL;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rcv_nxt = STOP;
        end
      end
      STOP: begin
        if (!expire) begin
          cnt_nxt = cnt - ONE;
        end else if (rx_s) begin
          data_nxt = shift;
          vld_nxt  = 1'b1;
          rcv_nxt  = IDLE;
        end else begin
          err_nxt = 1'b1;
          cnt_nxt = '0;
          rcv_nxt = ARM;
        end
      end
      default: rcv_nxt = ARM;
    endcase
  end

  // A fresh GO in PWR2 wins over a simultaneous dismount.
  always_comb begin
    auth_nxt = auth;
    case (auth)
      OFF:  if (vld_r && data_r == GO_CODE) auth_nxt = PWR1;
      PWR1: if (vld_r && data_r == STOP_CODE) auth_nxt = bus.rider_off ? OFF : PWR2;
      PWR2: begin
        if (vld_r && data_r == GO_CODE) auth_nxt = PWR1;
        else if (bus.rider_off)         auth_nxt = OFF;
      end
      default: auth_nxt = OFF;
    endcase
  end

  assign bus.rx_data  = data_r;
  assign bus.byte_vld = vld_r;
  assign bus.frm_err  = err_r;
  assign bus.pwr_up   = pwr_r;
endmodule

// File: tb/tb_uart_auth_rcv.sv
// tb/tb_uart_auth_rcv.sv - randomized and directed bench for uart_auth_rcv with reference model
module tb_uart_auth_rcv;
  localparam int         B  = 32;
  localparam logic [7:0] GO = 8'h47;
  localparam logic [7:0] ST = 8'h53;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_auth_rcv_if bus();

  uart_auth_rcv #(.BAUD_DIV(B), .GO_CODE(GO), .STOP_CODE(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } ev_t;

  ev_t        evq[$];
  int         total  = 0;
  int         passed = 0;
  int         cyc    = 0;
  int         m_auth = 0;     // 0 unpowered, 1 powered, 2 powered awaiting dismount
  logic [7:0] m_rx   = 8'h00;
  bit         m_live = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t        ev;
    bit         got;
    logic [7:0] b;
    int         lat;
    got = 1'b0;
    b   = 8'h00;
    if (rst) begin
      m_auth = 0;
      m_rx   = 8'h00;
      evq.delete();
      m_live = 1'b1;
    end else if (m_live) begin
      chk("pwr_up", {31'd0, bus.pwr_up}, {31'd0, m_auth != 0});
      if (bus.byte_vld && bus.frm_err) chk("pulse_exclusive", 32'd1, 32'd0);
      if (bus.byte_vld || bus.frm_err) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, bus.byte_vld, bus.frm_err}, 32'd0);
        end else begin
          ev = evq.pop_front();
          chk("pulse_kind", {31'd0, bus.frm_err}, {31'd0, ev.err});
          if (!ev.err) begin
            lat = cyc - ev.t0;
            chk("latency_window",
                {31'd0, (lat >= (19 * B) / 2 + 1) && (lat <= (19 * B) / 2 + 5)}, 32'd1);
            m_rx = ev.data;
            got  = 1'b1;
            b    = ev.data;
          end
        end
      end
      chk("rx_data", {24'd0, bus.rx_data}, {24'd0, m_rx});
      case (m_auth)
        0: if (got && b == GO) m_auth = 1;
        1: if (got && b == ST) m_auth = bus.rider_off ? 0 : 2;
        default: begin
          if (got && b == GO)     m_auth = 1;
          else if (bus.rider_off) m_auth = 0;
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit stop_ok, input int abort_bit);
    if (abort_bit < 0) evq.push_back('{err: !stop_ok, data: d, t0: cyc});
    bus.RX = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        tick(B / 2);
        rst    = 1'b1;
        bus.RX = 1'b1;
        tick(2);
        rst = 1'b0;
        return;
      end
      bus.RX = d[i];
      tick(B);
    end
    bus.RX = stop_ok;
    tick(B);
    bus.RX = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * B && evq.size() != 0; i++) tick(1);
    chk("drain", evq.size(), 32'd0);
  endtask

  initial begin
    bit         prev_ok;
    int         sel;
    logic [7:0] d;
    bit         ok;
    bus.RX        = 1'b1;
    bus.rider_off = 1'b0;
    rst           = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_pwr_up",   {31'd0, bus.pwr_up},   32'd0);
    chk("rst_rx_data",  {24'd0, bus.rx_data},  32'd0);
    chk("rst_byte_vld", {31'd0, bus.byte_vld}, 32'd0);
    chk("rst_frm_err",  {31'd0, bus.frm_err},  32'd0);
    tick(B + 5);

    send(GO, 1'b1, -1); drain(); tick(2);
    chk("go_powers_up", {31'd0, bus.pwr_up}, 32'd1);

    bus.rider_off = 1'b0;
    send(ST, 1'b1, -1); drain(); tick(3);
    chk("stop_with_rider", {31'd0, bus.pwr_up}, 32'd1);
    bus.rider_off = 1'b1; tick(3);
    chk("rider_steps_off", {31'd0, bus.pwr_up}, 32'd0);
    bus.rider_off = 1'b0;

    send(GO, 1'b1, -1); drain();
    bus.rider_off = 1'b1;
    send(ST, 1'b1, -1); drain(); tick(2);
    chk("stop_no_rider", {31'd0, bus.pwr_up}, 32'd0);
    send(8'h41, 1'b1, -1); drain(); tick(2);
    chk("other_byte", {31'd0, bus.pwr_up}, 32'd0);
    bus.rider_off = 1'b0;

    send(GO, 1'b0, -1); drain(); tick(B + 5);
    chk("frame_error_no_power", {31'd0, bus.pwr_up}, 32'd0);
    send(GO, 1'b1, -1); drain(); tick(2);
    chk("go_after_frame_error", {31'd0, bus.pwr_up}, 32'd1);

    bus.RX = 1'b0; tick(B / 4);
    bus.RX = 1'b1; tick(2 * B);
    send(ST, 1'b1, -1); drain(); tick(2);
    chk("stop_after_glitch", {24'd0, bus.rx_data}, {24'd0, ST});
    bus.rider_off = 1'b1; tick(3);
    chk("dismount_after_glitch", {31'd0, bus.pwr_up}, 32'd0);
    bus.rider_off = 1'b0;

    send(GO, 1'b1, -1); drain(); tick(2);
    send(GO, 1'b1, 4);
    chk("reset_mid_frame", {31'd0, bus.pwr_up}, 32'd0);
    tick(B + 5);
    send(GO, 1'b1, -1); drain(); tick(2);
    chk("go_after_reset", {31'd0, bus.pwr_up}, 32'd1);

    prev_ok = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      d   = (sel == 0) ? GO : (sel == 1) ? ST : 8'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      bus.rider_off = ($urandom_range(0, 2) == 0);
      if (!prev_ok || $urandom_range(0, 1) == 0) tick(B + 5);
      send(d, ok, -1);
      prev_ok = ok;
    end
    drain();
    tick(B + 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
